mem_bus: RTL
============

# mem_bus

Parametrised data-side memory subsystem for the single-cycle core. It decodes the core's data address into data RAM, stack RAM and a UART peripheral, and returns every read through one registered read mux, so there is no shared-bus contention. The UART side adds a TX FIFO with an 8N1 serialiser and a status register. A `stall` handshake holds the core while a write targets a full FIFO. It sits between the core's load/store path and the physical memories; instruction fetch stays outside this block.

## Interface
- `DATA_W`, 32, data word width (≥ 8).
- `ADDR_W`, 16, byte address width.
- `DATA_DEPTH`, 1024, data RAM words (power of 2).
- `STACK_DEPTH`, 256, stack RAM words (power of 2).
- `FIFO_DEPTH`, 8, UART TX FIFO entries (power of 2, ≥ 2).
- `CLKS_PER_BIT`, 16, clock cycles per UART bit (≥ 2).
- `DATA_BASE` / `STACK_BASE` / `UART_BASE`, 16'h0000 / 16'hE000 / 16'hF000, region base addresses; each base is aligned to its region size.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  data access request.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  byte address; bits [1:0] are ignored (word access only).
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data, registered.
- `rvalid`  out  1  one-cycle pulse; `rdata` is valid in that cycle.
- `stall`  out  1  combinational; the request is not accepted this cycle.
- `err`  out  1  one-cycle pulse for an accepted access to an unmapped address.
- `uart_tx`  out  1  serial output; idles high.

## Operation
- A request is accepted when `req && !stall`.
- Region decode:
  - Data: `DATA_BASE .. DATA_BASE + 4*DATA_DEPTH - 1`.
  - Stack: `STACK_BASE .. STACK_BASE + 4*STACK_DEPTH - 1`.
  - UART: `UART_BASE + 0` is TXDATA; `UART_BASE + 4` is STATUS.
  - Anything else is unmapped.
- RAM word index is `addr[log2(depth)+1:2]` relative to the region base.
- RAM write: memory updates at the edge of acceptance.
- RAM read: data appears on `rdata` at the following edge.
- TXDATA write pushes `wdata[7:0]`. TXDATA read returns 0.
- STATUS read returns:
  - bit0 = fifo_full
  - bit1 = fifo_empty
  - bit2 = tx_busy
  - bits[3+log2(FIFO_DEPTH):3] = fifo_count
  - all other bits 0
- STATUS write is ignored, with no `err`.
- Unmapped access: read returns 0 with `rvalid` asserted; write is ignored; `err` pulses in both cases.
- `stall = req && we && (addr hits TXDATA) && fifo_full`. `stall` is 0 for every other access, including reads.
- FIFO push and serialiser pop in the same cycle are both honoured; count is unchanged.
- Serialiser FSM:
  - IDLE → START when FIFO is not empty; the byte is popped on that transition.
  - START holds `uart_tx = 0` for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA sends 8 bits, LSB first, CLKS_PER_BIT cycles each, then goes to STOP.
  - STOP holds `uart_tx = 1` for CLKS_PER_BIT cycles, then goes to START if FIFO is not empty, else IDLE.
  - `tx_busy` = state ≠ IDLE.

## Timing
- Reset values:
  - `rdata` = 0, `rvalid` = 0, `err` = 0, `uart_tx` = 1.
  - FIFO empty (pointers and count 0), FSM = IDLE, baud and bit counters 0.
  - RAM contents are not reset.
- Read latency is exactly 1 cycle: acceptance in cycle N gives `rvalid` and `rdata` in cycle N+1.
- `rdata` holds its last value while `rvalid` = 0.
- `err` is asserted in cycle N+1 for an unmapped access accepted in cycle N.
- Back-to-back reads are supported, one per cycle.
- A read of STATUS in the cycle of a push returns the pre-push count.
- The first start bit begins on the edge after the push into an empty FIFO with FSM IDLE.
- A frame lasts 10 × CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- FIFO pointers wrap modulo FIFO_DEPTH; count saturates neither way because the stall guard prevents overflow.
- Reset mid-frame: `uart_tx` returns to 1 immediately (asynchronous) and FIFO contents are discarded.
- Reset during a pending read: `rvalid` is 0 after reset.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the tx state enum (IDLE, START, DATA, STOP);
  - STATUS bit-position constants;
  - the TXDATA/STATUS offsets (0, 4).
- One natural sub-module: `uart_tx_fifo`, containing the FIFO, baud counter and serialiser FSM, with push/full/empty/count/busy/tx ports.
- Decode logic and RAM arrays stay in the top level.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0010 and read 0x0010 → `rvalid` one cycle later with `rdata` = 0xDEADBEEF.
- Write 0x12345678 to 0xE000 and 0xCAFEF00D to 0x0000, then read both → each returns its own value (no aliasing between regions).
- Read 0x8000 → `rdata` = 0, `rvalid` = 1, `err` = 1 for one cycle; a write to 0x8000 changes no RAM word.
- Push 0xA5 to 0xF000 with CLKS_PER_BIT = 4 → `uart_tx` sequence is 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; STATUS reads `tx_busy` = 1 during the frame.
- Push FIFO_DEPTH + 2 bytes (0x01..0x0A, FIFO_DEPTH = 8) back-to-back → `stall` asserts when the FIFO is full and releases on each pop; all 10 bytes are transmitted in order with no gap.
- Assert `reset` mid-data-bit → `uart_tx` = 1 and STATUS reads 0x2 (empty) after release.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-side memory subsystem: UART serialiser
// states, STATUS register bit positions and UART register offsets.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_COUNT_LSB = 3;

  localparam int TXDATA_OFS = 0;
  localparam int STATUS_OFS = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser with a baud counter.
// A byte leaves the FIFO as its frame's start bit begins.
module uart_tx_fifo
  import mem_bus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  tx_state_t     state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          baud_done, pop;

  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign busy      = (state_reg != TX_IDLE);
  assign baud_done = (baud_reg == BAUD_LAST);
  // Pop exactly when a new frame begins, so back-to-back frames have no gap.
  assign pop = !empty && ((state_reg == TX_IDLE) ||
                          (state_reg == TX_STOP && baud_done));

  always_comb begin
    case (state_reg)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shift_reg[0];
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= TX_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        shift_reg  <= fifo_mem[rd_ptr_reg];
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);

      case (state_reg)
        TX_IDLE: begin
          baud_reg <= '0;
          if (pop) state_reg <= TX_START;
        end
        TX_START: begin
          if (baud_done) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= TX_DATA;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_reg == 3'd7) state_reg <= TX_STOP;
            else                 bit_reg   <= bit_reg + 3'd1;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= pop ? TX_START : TX_IDLE;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bus.sv
// Data-side memory subsystem: decodes core loads/stores into data RAM, stack
// RAM and the UART, returning all reads through one registered read mux.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int DATA_DEPTH   = 1024,
  parameter int STACK_DEPTH  = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter logic [ADDR_W-1:0] DATA_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] STACK_BASE = 16'hE000,
  parameter logic [ADDR_W-1:0] UART_BASE  = 16'hF000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err,
  output logic              uart_tx
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int SAW = $clog2(STACK_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] TXDATA_ADDR = UART_BASE + ADDR_W'(TXDATA_OFS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = UART_BASE + ADDR_W'(STATUS_OFS);

  localparam logic [1:0] SEL_MISC  = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_STACK = 2'd2;

  logic [DATA_W-1:0] data_mem  [DATA_DEPTH];
  logic [DATA_W-1:0] stack_mem [STACK_DEPTH];
  logic [DATA_W-1:0] data_q, stack_q, misc_q, status_word;
  logic [1:0]        sel_reg;
  logic              rvalid_reg, err_reg;
  logic              data_hit, stack_hit, txdata_hit, status_hit, unmapped;
  logic              accept, push;
  logic              fifo_full, fifo_empty, tx_busy;
  logic [CW-1:0]     fifo_count;
  logic              unused_addr_bits;

  // Bases are aligned to their region size, so a region hit is an upper-bit match.
  assign data_hit   = (addr[ADDR_W-1:DAW+2] == DATA_BASE[ADDR_W-1:DAW+2]);
  assign stack_hit  = (addr[ADDR_W-1:SAW+2] == STACK_BASE[ADDR_W-1:SAW+2]);
  assign txdata_hit = (addr[ADDR_W-1:2] == TXDATA_ADDR[ADDR_W-1:2]);
  assign status_hit = (addr[ADDR_W-1:2] == STATUS_ADDR[ADDR_W-1:2]);
  assign unmapped   = !(data_hit || stack_hit || txdata_hit || status_hit);
  assign unused_addr_bits = ^addr[1:0];

  assign stall  = req && we && txdata_hit && fifo_full;
  assign accept = req && !stall;
  assign push   = accept && we && txdata_hit;

  always_comb begin
    status_word = '0;
    status_word[STATUS_FULL_BIT]            = fifo_full;
    status_word[STATUS_EMPTY_BIT]           = fifo_empty;
    status_word[STATUS_BUSY_BIT]            = tx_busy;
    status_word[STATUS_COUNT_LSB +: CW]     = fifo_count;
  end

  always_ff @(posedge clk) begin
    if (accept && data_hit) begin
      if (we) data_mem[addr[DAW+1:2]] <= wdata;
      else    data_q <= data_mem[addr[DAW+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && stack_hit) begin
      if (we) stack_mem[addr[SAW+1:2]] <= wdata;
      else    stack_q <= stack_mem[addr[SAW+1:2]];
    end
  end

  // Select and non-RAM read data are captured together; unchanged select and
  // RAM output registers keep rdata stable between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg    <= SEL_MISC;
      misc_q     <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= accept && !we;
      err_reg    <= accept && unmapped;
      if (accept && !we) begin
        sel_reg <= data_hit ? SEL_DATA : (stack_hit ? SEL_STACK : SEL_MISC);
        misc_q  <= status_hit ? status_word : '0;
      end
    end
  end

  always_comb begin
    case (sel_reg)
      SEL_DATA:  rdata = data_q;
      SEL_STACK: rdata = stack_q;
      default:   rdata = misc_q;
    endcase
  end

  assign rvalid = rvalid_reg;
  assign err    = err_reg;

  uart_tx_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(wdata[7:0]),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .busy     (tx_busy),
    .tx       (uart_tx)
  );

endmodule
